ps2_move_decoder: RTL and testbench



---
 rtl/ps2_move_decoder_if.sv | 20 ++
 rtl/ps2_move_decoder.sv | 248 ++++++++++++++++++++++++
 tb/tb_ps2_move_decoder.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_move_decoder_if.sv
// Connector-side PS/2 lines and the decoded move/debug outputs of ps2_move_decoder.
// The master drives the raw PS/2 lines; the slave (the decoder) drives the results.
interface ps2_move_decoder_if;
   logic       PS2C;
   logic       PS2D;
   logic [3:0] move;
   logic [7:0] scan_code;
   logic       key_valid;
   logic       frame_err;

   modport master (
      output PS2C, PS2D,
      input  move, scan_code, key_valid, frame_err
   );

   modport slave (
      input  PS2C, PS2D,
      output move, scan_code, key_valid, frame_err
   );
endinterface : ps2_move_decoder_if

// File: rtl/ps2_move_decoder.sv
// PS/2 keyboard front end: synchronise and debounce PS2C/PS2D, deframe 11-bit
// frames, decode set-2 make/break sequences for arrows and WASD, and drive a
// one-hot move bus that follows the most recently pressed, still held direction.
module ps2_move_decoder #(
   parameter int TICK_DIV   = 4,
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 20000
) (
   input logic              clk,
   input logic              clr,
   ps2_move_decoder_if.slave bus
);

   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [7:0] CODE_EXT = 8'hE0;
   localparam logic [7:0] CODE_BRK = 8'hF0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK
   } state_e;

   // ---------------------------------------------------------------------------
   // Input conditioning
   // ---------------------------------------------------------------------------
   logic [1:0]            c_sync_q, d_sync_q;
   logic [TICK_W-1:0]     tick_cnt_q;
   logic                  tick;
   logic [FILTER_LEN-1:0] c_shift_q, d_shift_q;
   logic                  c_filt_q, d_filt_q, c_prev_q;
   logic                  fall;

   assign tick = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
   assign fall = c_prev_q & ~c_filt_q;

   // Two-flop synchronisers; idle PS/2 lines are high, so reset to ones.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (clr) begin
         c_sync_q <= 2'b11;
         d_sync_q <= 2'b11;
      end else begin
         c_sync_q <= {c_sync_q[0], bus.PS2C};
         d_sync_q <= {d_sync_q[0], bus.PS2D};
      end
   end

   // Free-running sample-tick divider.
   always_ff @(posedge clk) begin
      if (clr || tick) tick_cnt_q <= '0;
      else             tick_cnt_q <= tick_cnt_q + TICK_W'(1);
   end

   // Majority-free debounce: a filtered line only moves once the whole window agrees.
   always_ff @(posedge clk) begin
      if (clr) begin
         c_shift_q <= '1;
         d_shift_q <= '1;
         c_filt_q  <= 1'b1;
         d_filt_q  <= 1'b1;
         c_prev_q  <= 1'b1;
      end else begin
         if (tick) begin
            c_shift_q <= {c_shift_q[FILTER_LEN-2:0], c_sync_q[1]};
            d_shift_q <= {d_shift_q[FILTER_LEN-2:0], d_sync_q[1]};
         end
         if (&c_shift_q)       c_filt_q <= 1'b1;
         else if (~|c_shift_q) c_filt_q <= 1'b0;
         if (&d_shift_q)       d_filt_q <= 1'b1;
         else if (~|d_shift_q) d_filt_q <= 1'b0;
         c_prev_q <= c_filt_q;
      end
   end

   // ---------------------------------------------------------------------------
   // Frame receiver
   // ---------------------------------------------------------------------------
   logic [3:0]      bit_cnt_q;
   logic [9:0]      frame_q;      // bits 0..9 of the frame once bit 10 arrives
   logic [TO_W-1:0] to_cnt_q;
   logic [7:0]      scan_code_q;
   logic            key_valid_q, frame_err_q;
   logic            frame_ok;

   // Start low, stop (sampled live as bit 10) high, odd parity over data+parity.
   assign frame_ok = ~frame_q[0] & d_filt_q & (^frame_q[9:1]);

   // Bit capture on each filtered falling clock edge, with stall timeout.
   always_ff @(posedge clk) begin
      if (clr) begin
         bit_cnt_q   <= '0;
         frame_q     <= '0;
         to_cnt_q    <= '0;
         scan_code_q <= '0;
         key_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         key_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         if (fall) begin
            to_cnt_q <= '0;
            if (bit_cnt_q == 4'd10) begin
               bit_cnt_q <= '0;
               if (frame_ok) begin
                  scan_code_q <= frame_q[8:1];
                  key_valid_q <= 1'b1;
               end else begin
                  frame_err_q <= 1'b1;
               end
            end else begin
               frame_q   <= {d_filt_q, frame_q[9:1]};
               bit_cnt_q <= bit_cnt_q + 4'd1;
            end
         end else if (bit_cnt_q != 4'd0) begin
            if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
               bit_cnt_q   <= '0;
               to_cnt_q    <= '0;
               frame_err_q <= 1'b1;
            end else begin
               to_cnt_q <= to_cnt_q + TO_W'(1);
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Make/break decoder
   // ---------------------------------------------------------------------------
   state_e     state_q, state_d;
   logic [7:0] held_q, held_d;     // [3:0] arrows, [7:4] WASD, indexed by direction
   logic [1:0] last_dir_q, last_dir_d;
   logic       last_vld_q, last_vld_d;
   logic [3:0] move_q, move_d;
   logic [3:0] dir_held;
   logic       is_prefix, is_ext, is_brk, key_hit;
   logic [1:0] key_dir;
   logic [2:0] held_idx;

   // Direction of a mapped key: {hit, dir}; dir 0 up, 1 down, 2 left, 3 right.
   function automatic logic [2:0] map_key(input logic ext, input logic [7:0] code);
      logic [2:0] res;
      res = 3'b000;
      if (ext) begin
         case (code)
            8'h75:   res = 3'b100;
            8'h72:   res = 3'b101;
            8'h6B:   res = 3'b110;
            8'h74:   res = 3'b111;
            default: res = 3'b000;
         endcase
      end else begin
         case (code)
            8'h1D:   res = 3'b100;
            8'h1B:   res = 3'b101;
            8'h1C:   res = 3'b110;
            8'h23:   res = 3'b111;
            default: res = 3'b000;
         endcase
      end
      return res;
   endfunction

   // Decoder state register.
   always_ff @(posedge clk) begin
      if (clr) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next decoder state: prefixes advance, anything else completes a sequence.
   // NOTE: every always_comb output is defaulted first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      if (frame_err_q) begin
         state_d = ST_IDLE;
      end else if (key_valid_q) begin
         case (state_q)
            ST_IDLE: begin
               if (scan_code_q == CODE_EXT)      state_d = ST_EXT;
               else if (scan_code_q == CODE_BRK) state_d = ST_BRK;
               else                              state_d = ST_IDLE;
            end
            ST_EXT: begin
               if (scan_code_q == CODE_BRK) state_d = ST_EXT_BRK;
               else                         state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Held-key bookkeeping and move selection from the post-update key state.
   always_comb begin
      held_d     = held_q;
      last_dir_d = last_dir_q;
      last_vld_d = last_vld_q;
      is_ext     = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
      is_brk     = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
      is_prefix  = ((state_q == ST_IDLE) && (scan_code_q == CODE_EXT || scan_code_q == CODE_BRK))
                || ((state_q == ST_EXT) && (scan_code_q == CODE_BRK));
      {key_hit, key_dir} = map_key(is_ext, scan_code_q);
      held_idx   = {~is_ext, key_dir};

      if (key_valid_q && !is_prefix && key_hit) begin
         if (is_brk) begin
            held_d[held_idx] = 1'b0;
         end else begin
            held_d[held_idx] = 1'b1;
            last_dir_d       = key_dir;
            last_vld_d       = 1'b1;
         end
      end

      dir_held = held_d[3:0] | held_d[7:4];
      move_d   = 4'b0000;
      if (last_vld_d && dir_held[last_dir_d]) begin
         move_d = 4'b0001 << last_dir_d;
      end else begin
         for (int i = 3; i >= 0; i--) begin
            if (dir_held[i]) move_d = 4'b0001 << i;
         end
      end
   end

   // Registered held mask, last-pressed direction and move output.
   always_ff @(posedge clk) begin
      if (clr) begin
         held_q     <= '0;
         last_dir_q <= '0;
         last_vld_q <= 1'b0;
         move_q     <= '0;
      end else begin
         held_q     <= held_d;
         last_dir_q <= last_dir_d;
         last_vld_q <= last_vld_d;
         move_q     <= move_d;
      end
   end

   assign bus.move      = move_q;
   assign bus.scan_code = scan_code_q;
   assign bus.key_valid = key_valid_q;
   assign bus.frame_err = frame_err_q;

endmodule : ps2_move_decoder

// File: tb/tb_ps2_move_decoder.sv
// Bench for ps2_move_decoder: directed scenarios plus random PS/2 frames, with a
// key-state model that tracks held keys per direction and the last press.
module tb_ps2_move_decoder;

   localparam int HALF    = 50;      // clk cycles per PS/2 clock half-period
   localparam int TIMEOUT = 20000;

   logic clk = 1'b0;
   logic clr;

   ps2_move_decoder_if bus();

   ps2_move_decoder #(
      .TICK_DIV   (4),
      .FILTER_LEN (8),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit m_ext, m_brk;
   bit arrow_held[4];
   bit letter_held[4];
   int last_dir;

   function void model_reset();
      m_ext = 0;
      m_brk = 0;
      last_dir = -1;
      for (int d = 0; d < 4; d++) begin
         arrow_held[d]  = 0;
         letter_held[d] = 0;
      end
   endfunction

   function automatic int lookup(input bit ext, input logic [7:0] b);
      if (ext) begin
         case (b)
            8'h75: return 0;
            8'h72: return 1;
            8'h6B: return 2;
            8'h74: return 3;
            default: return -1;
         endcase
      end
      case (b)
         8'h1D: return 0;
         8'h1B: return 1;
         8'h1C: return 2;
         8'h23: return 3;
         default: return -1;
      endcase
   endfunction

   function void model_byte(input logic [7:0] b);
      int d;
      if (!m_ext && !m_brk && b == 8'hE0) begin
         m_ext = 1;
      end else if (!m_brk && b == 8'hF0) begin
         m_brk = 1;
      end else begin
         d = lookup(m_ext, b);
         if (d >= 0) begin
            if (m_brk) begin
               if (m_ext) arrow_held[d] = 0; else letter_held[d] = 0;
            end else begin
               if (m_ext) arrow_held[d] = 1; else letter_held[d] = 1;
               last_dir = d;
            end
         end
         m_ext = 0;
         m_brk = 0;
      end
   endfunction

   function automatic logic [3:0] model_move();
      bit h[4];
      for (int d = 0; d < 4; d++) h[d] = arrow_held[d] | letter_held[d];
      if (last_dir >= 0 && h[last_dir]) return 4'(1 << last_dir);
      for (int d = 0; d < 4; d++) if (h[d]) return 4'(1 << d);
      return 4'b0000;
   endfunction

   // ---------------- scoreboard / monitor ----------------
   logic [7:0] exp_q[$];
   int exp_err = 0;
   int kv_cnt  = 0;
   int fe_cnt  = 0;

   always @(negedge clk) begin
      logic [7:0] b;
      if (clr) begin
         model_reset();
      end else begin
         check("move", bus.move, model_move());
         if (bus.key_valid || bus.frame_err)
            check("strobe_exclusive", bus.key_valid & bus.frame_err, 0);
         if (bus.key_valid) begin
            kv_cnt++;
            check("kv_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               b = exp_q.pop_front();
               check("scan_code", bus.scan_code, b);
               model_byte(b);
            end
         end
         if (bus.frame_err) begin
            fe_cnt++;
            check("fe_expected", exp_err > 0, 1);
            if (exp_err > 0) exp_err--;
            m_ext = 0;
            m_brk = 0;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic ps2_bit(input logic v);
      bus.PS2D = v;
      repeat (HALF) @(negedge clk);
      bus.PS2C = 1'b0;
      repeat (HALF) @(negedge clk);
      bus.PS2C = 1'b1;
   endtask

   // kind: 0 good, 1 parity flipped, 2 stop low, 3 start high
   task automatic send_bits(input logic [7:0] b, input int kind, input int nbits);
      logic [10:0] f;
      f[0]   = 1'b0;
      f[8:1] = b;
      f[9]   = ~^b;
      f[10]  = 1'b1;
      if (kind == 1) f[9]  = ~f[9];
      if (kind == 2) f[10] = 1'b0;
      if (kind == 3) f[0]  = 1'b1;
      for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
      bus.PS2D = 1'b1;
   endtask

   task automatic send(input logic [7:0] b, input int kind);
      if (kind == 0) exp_q.push_back(b);
      else           exp_err++;
      send_bits(b, kind, 11);
      repeat (150) @(negedge clk);
   endtask

   logic [7:0] pool[15] = '{8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74,
                            8'h1D, 8'h1B, 8'h1C, 8'h23, 8'hE1, 8'hAA, 8'hFA};

   // ---------------- main sequence ----------------
   initial begin
      int kv0, fe0;
      int k;
      logic [7:0] rb;
      bus.PS2C = 1'b1;
      bus.PS2D = 1'b1;
      clr = 1'b1;
      model_reset();
      repeat (4) @(negedge clk);
      check("rst_move", bus.move, 4'h0);
      check("rst_scan_code", bus.scan_code, 8'h00);
      check("rst_key_valid", bus.key_valid, 0);
      check("rst_frame_err", bus.frame_err, 0);
      clr = 1'b0;
      repeat (20) @(negedge clk);

      // Up arrow make
      kv0 = kv_cnt;
      send(8'hE0, 0);
      send(8'h75, 0);
      check("up_kv_count", kv_cnt - kv0, 2);
      check("up_scan_code", bus.scan_code, 8'h75);
      check("up_move", bus.move, 4'b0001);

      // D over up, release D, release up
      send(8'h23, 0);
      check("d_move", bus.move, 4'b1000);
      send(8'hF0, 0); send(8'h23, 0);
      check("d_release_move", bus.move, 4'b0001);
      send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 0);
      check("up_release_move", bus.move, 4'b0000);

      // Parity error then good A
      fe0 = fe_cnt;
      send(8'h1C, 1);
      check("parity_fe_count", fe_cnt - fe0, 1);
      check("parity_scan_kept", bus.scan_code, 8'h75);
      check("parity_move_kept", bus.move, 4'b0000);
      send(8'h1C, 0);
      check("a_move", bus.move, 4'b0100);

      // Partial frame and stall past the timeout
      fe0 = fe_cnt;
      exp_err++;
      send_bits(8'h1B, 0, 5);
      repeat (TIMEOUT + 500) @(negedge clk);
      check("timeout_fe_count", fe_cnt - fe0, 1);
      send(8'h1B, 0);
      check("s_scan_code", bus.scan_code, 8'h1B);
      check("s_move", bus.move, 4'b0010);

      // Short glitch on PS2C produces nothing
      kv0 = kv_cnt;
      fe0 = fe_cnt;
      bus.PS2C = 1'b0;
      #40;
      bus.PS2C = 1'b1;
      repeat (200) @(negedge clk);
      check("glitch_no_kv", kv_cnt, kv0);
      check("glitch_no_fe", fe_cnt, fe0);

      // Typematic right arrow
      for (int i = 0; i < 3; i++) begin
         send(8'hE0, 0); send(8'h74, 0);
         check("typematic_move", bus.move, 4'b1000);
      end

      // Reset mid-frame with W held
      send(8'h1D, 0);
      check("w_move", bus.move, 4'b0001);
      fe0 = fe_cnt;
      send_bits(8'h55, 0, 6);
      @(negedge clk);
      clr = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst_move", bus.move, 4'h0);
      check("midrst_scan_code", bus.scan_code, 8'h00);
      check("midrst_key_valid", bus.key_valid, 0);
      check("midrst_frame_err", bus.frame_err, 0);
      clr = 1'b0;
      repeat (100) @(negedge clk);
      check("midrst_no_fe", fe_cnt, fe0);
      send(8'h1D, 0);
      check("w_after_rst_move", bus.move, 4'b0001);

      // Random frames against the model
      for (int i = 0; i < 20; i++) begin
         k = ($urandom_range(0, 9) < 8) ? 0 : int'($urandom_range(1, 3));
         k = (k > 3) ? 3 : k;
         rb = pool[$urandom_range(0, 14)];
         if ($urandom_range(0, 9) == 0) rb = 8'($urandom);
         send(rb, k);
      end

      repeat (200) @(negedge clk);
      check("all_bytes_seen", exp_q.size(), 0);
      check("all_errors_seen", exp_err, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule : tb_ps2_move_decoder
